gate_sweep_checker: RTL and testbench

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_checker.sv | 153 +++++++++++++++
 tb/tb_gate_sweep_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// gate_sweep_checker
//
// Exhaustively exercises a downstream 2-input AND stage. A sweep drives the
// four input vectors {x1,x2} = 00, 10, 01, 11, holding each one for DWELL
// cycles. On the last cycle of each hold the returned z is compared with
// x1 & x2. The block counts mismatching vectors and records the index of the
// first one.
//
// Ports
//   clk         in   single clock, rising edge active
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a sweep (ignored while a sweep is running)
//   rpt         in   when high at the end of a sweep, start the next one
//   z           in   result from the AND stage under test
//   x1, x2      out  stimulus to the AND stage (0 when no sweep is running)
//   busy        out  sweep in progress
//   done        out  sweep finished, held until the next sweep starts
//   pass        out  done with no mismatches
//   err_count   out  mismatching vectors in the current or last sweep (0..4)
//   first_fail  out  index of the first mismatching vector (valid if err_count != 0)
//   vec_idx     out  index of the vector currently driven
// -----------------------------------------------------------------------------
module gate_sweep_checker #(
  parameter int unsigned DWELL = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rpt,
  input  logic       z,
  output logic       x1,
  output logic       x2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } state_e;

  localparam logic [7:0] LastCnt = 8'(DWELL - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] err_q, err_d;
  logic [1:0] ff_q, ff_d;
  // High for the first cycle of an automatically repeated sweep, while the
  // previous sweep's result is still presented.
  logic       hold_q, hold_d;

  logic       drv_x1, drv_x2;
  logic       sample;
  logic       mismatch;
  logic [2:0] err_base;
  logic [1:0] ff_base;

  // Vector table: index 0 = 00, 1 = 10, 2 = 01, 3 = 11 as {x1,x2}, which is
  // simply x1 = idx[0], x2 = idx[1].
  assign drv_x1 = vec_q[0];
  assign drv_x2 = vec_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    err_d    = err_q;
    ff_d     = ff_q;
    hold_d   = 1'b0;

    sample   = (state_q == StDrive) && (cnt_q == LastCnt);
    mismatch = sample && (z != (drv_x1 & drv_x2));
    // The held result is discarded at the end of the hold cycle; any sample
    // on that same edge (DWELL == 1) accumulates onto a cleared tally.
    err_base = hold_q ? 3'd0 : err_q;
    ff_base  = hold_q ? 2'd0 : ff_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          cnt_d   = 8'd0;
          vec_d   = 2'd0;
          err_d   = 3'd0;
          ff_d    = 2'd0;
        end
      end
      StDrive: begin
        err_d = err_base;
        ff_d  = ff_base;
        if (mismatch) begin
          err_d = err_base + 3'd1;
          if (err_base == 3'd0) begin
            ff_d = vec_q;
          end
        end
        if (sample) begin
          cnt_d = 8'd0;
          if (vec_q != 2'd3) begin
            vec_d = vec_q + 2'd1;
          end else begin
            vec_d = 2'd0;
            if (rpt) begin
              hold_d = 1'b1;
            end else begin
              state_d = StDone;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      vec_q   <= 2'd0;
      err_q   <= 3'd0;
      ff_q    <= 2'd0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      hold_q  <= hold_d;
    end
  end

  assign busy       = (state_q == StDrive);
  assign done       = (state_q == StDone) || hold_q;
  assign pass       = done && (err_q == 3'd0);
  assign x1         = busy && drv_x1;
  assign x2         = busy && drv_x2;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign vec_idx    = vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_checker
//
// Two instances run side by side from shared stimulus: DWELL = 10 and
// DWELL = 1. A behavioural model tracks each sweep as a position within a
// 4*DWELL-cycle window and is compared against every output on every
// falling clock edge. Directed phases pin literal results; a random phase
// mixes AND-stage fault modes, start/rpt traffic and asynchronous resets.
// -----------------------------------------------------------------------------
module tb_gate_sweep_checker;

  localparam int unsigned Dw0 = 10;
  localparam int unsigned Dw1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rpt = 1'b0;
  logic rbit = 1'b0;
  int   mode = 0;  // 0: good AND, 1: z tied 0, 2: z tied 1, 3: random z

  logic [1:0]       z_v, x1_v, x2_v, busy_v, done_v, pass_v;
  logic [1:0][2:0]  ec_v;
  logic [1:0][1:0]  ff_v, vi_v;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // {x1,x2} per vector index
  logic [1:0] vtab [4];
  initial begin
    vtab[0] = 2'b00;
    vtab[1] = 2'b10;
    vtab[2] = 2'b01;
    vtab[3] = 2'b11;
  end

  always #5 clk = ~clk;

  gate_sweep_checker #(.DWELL(Dw0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rpt(rpt), .z(z_v[0]),
    .x1(x1_v[0]), .x2(x2_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(ec_v[0]), .first_fail(ff_v[0]), .vec_idx(vi_v[0])
  );

  gate_sweep_checker #(.DWELL(Dw1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .rpt(rpt), .z(z_v[1]),
    .x1(x1_v[1]), .x2(x2_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(ec_v[1]), .first_fail(ff_v[1]), .vec_idx(vi_v[1])
  );

  function automatic logic zfun(input int md, input logic a, input logic b, input logic r);
    case (md)
      0:       return a & b;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return r;
    endcase
  endfunction

  always_comb begin
    z_v = '0;
    for (int i = 0; i < 2; i++) begin
      z_v[i] = zfun(mode, x1_v[i], x2_v[i], rbit);
    end
  end

  // ---------------- behavioural model ----------------
  int unsigned dw [2];
  bit m_busy [2];
  bit m_done [2];
  bit m_hold [2];
  int m_pos  [2];
  int m_errs [2];
  int m_ff   [2];

  initial begin
    dw[0] = Dw0;
    dw[1] = Dw1;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_hold[i] = 0;
      m_pos[i] = 0; m_errs[i] = 0; m_ff[i] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_done[i] = 0; m_hold[i] = 0;
        m_pos[i] = 0; m_errs[i] = 0; m_ff[i] = 0;
      end else if (m_busy[i]) begin
        int v;
        logic [1:0] xv;
        v  = m_pos[i] / int'(dw[i]);
        xv = vtab[v];
        if (m_hold[i]) begin
          m_hold[i] = 0; m_done[i] = 0; m_errs[i] = 0; m_ff[i] = 0;
        end
        if ((m_pos[i] + 1) % int'(dw[i]) == 0) begin
          if (zfun(mode, xv[1], xv[0], rbit) != (xv[1] & xv[0])) begin
            if (m_errs[i] == 0) m_ff[i] = v;
            m_errs[i]++;
          end
        end
        if (m_pos[i] == 4 * int'(dw[i]) - 1) begin
          m_pos[i]  = 0;
          m_done[i] = 1;
          if (rpt) m_hold[i] = 1;
          else     m_busy[i] = 0;
        end else begin
          m_pos[i]++;
        end
      end else if (start) begin
        m_busy[i] = 1; m_done[i] = 0; m_pos[i] = 0; m_errs[i] = 0; m_ff[i] = 0;
      end
    end
  end

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] xe;
        int ve;
        ve = m_busy[i] ? m_pos[i] / int'(dw[i]) : 0;
        xe = m_busy[i] ? vtab[ve] : 2'b00;
        chk("busy", i, int'(busy_v[i]), int'(m_busy[i]));
        chk("done", i, int'(done_v[i]), int'(m_done[i]));
        chk("pass", i, int'(pass_v[i]), int'(m_done[i] && m_errs[i] == 0));
        chk("x1x2", i, int'({x1_v[i], x2_v[i]}), int'(xe));
        chk("vec_idx", i, int'(vi_v[i]), ve);
        chk("err_count", i, int'(ec_v[i]), m_errs[i]);
        if (m_errs[i] != 0) chk("first_fail", i, int'(ff_v[i]), m_ff[i]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    wait_cycles(2);
    for (int i = 0; i < 2; i++) begin
      chk("reset_outs", i, int'({x1_v[i], x2_v[i], busy_v[i], done_v[i], pass_v[i],
                                 ec_v[i], ff_v[i], vi_v[i]}), 0);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;
    wait_cycles(2);

    // Good AND stage: timing of vectors and completion.
    mode = 0;
    pulse_start();
    wait_cycles(4);
    chk("dw1_done_k4", 1, int'(done_v[1]), 1);
    chk("dw1_pass_k4", 1, int'(pass_v[1]), 1);
    wait_cycles(5);
    chk("x_k9", 0, int'({x1_v[0], x2_v[0]}), 0);
    wait_cycles(1);
    chk("x_k10", 0, int'({x1_v[0], x2_v[0]}), 2);
    wait_cycles(29);
    chk("done_k39", 0, int'(done_v[0]), 0);
    wait_cycles(1);
    chk("done_k40", 0, int'(done_v[0]), 1);
    chk("pass_k40", 0, int'(pass_v[0]), 1);
    chk("err_k40", 0, int'(ec_v[0]), 0);

    // z stuck at 0: only vector 3 fails.
    mode = 1;
    pulse_start();
    wait_cycles(40);
    chk("t0_err", 0, int'(ec_v[0]), 1);
    chk("t0_ff", 0, int'(ff_v[0]), 3);
    chk("t0_pass", 0, int'(pass_v[0]), 0);
    chk("t0_model_err", 0, m_errs[0], 1);
    chk("t0_err", 1, int'(ec_v[1]), 1);

    // z stuck at 1: vectors 0,1,2 fail.
    mode = 2;
    pulse_start();
    wait_cycles(40);
    chk("t1_err", 0, int'(ec_v[0]), 3);
    chk("t1_ff", 0, int'(ff_v[0]), 0);
    chk("t1_pass", 0, int'(pass_v[0]), 0);
    chk("t1_model_ff", 0, m_ff[0], 0);
    chk("t1_err", 1, int'(ec_v[1]), 3);

    // Asynchronous reset mid-sweep, then no start.
    mode = 0;
    pulse_start();
    wait_cycles(14);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_outs", i, int'({x1_v[i], x2_v[i], busy_v[i], done_v[i], pass_v[i],
                                     ec_v[i], ff_v[i], vi_v[i]}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(10);
    chk("idle_after_rst", 0, int'(busy_v[0]), 0);
    chk("idle_after_rst", 1, int'(busy_v[1]), 0);
    chk("no_done_after_rst", 0, int'(done_v[0]), 0);

    // start re-pulsed during DRIVE must not disturb timing.
    pulse_start();
    wait_cycles(5);
    pulse_start();
    wait_cycles(33);
    chk("restart_done_k39", 0, int'(done_v[0]), 0);
    wait_cycles(1);
    chk("restart_done_k40", 0, int'(done_v[0]), 1);

    // Back-to-back sweeps with rpt.
    rpt = 1'b1;
    pulse_start();
    wait_cycles(40);
    chk("rpt_hold_done", 0, int'(done_v[0]), 1);
    chk("rpt_hold_busy", 0, int'(busy_v[0]), 1);
    chk("rpt_hold_pass", 0, int'(pass_v[0]), 1);
    wait_cycles(1);
    chk("rpt_after_hold_done", 0, int'(done_v[0]), 0);
    rpt = 1'b0;
    wait_cycles(39);
    chk("rpt_second_done", 0, int'(done_v[0]), 1);
    chk("rpt_second_busy", 0, int'(busy_v[0]), 0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rbit  = 1'($urandom);
      start = ($urandom_range(0, 15) == 0);
      rpt   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) mode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    rpt   = 1'b0;
    wait_cycles(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
